// File: rtl/mc_control_unit.sv
// Multicycle control unit: a Moore FSM that steps each instruction through
// fetch, decode, execute, memory and writeback. It issues the ULA operation
// code, operand selects and write enables, and uses the ULA Z flag for beq.
module mc_control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alu_control,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_write_en,
  output logic       i_or_d,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BEQ    = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Plain vector so the encoding is visible on the debug port and so codes
  // 12-15 are representable.
  logic [3:0] state_q;
  logic [3:0] state_d;

  // Raw enables before reset masking.
  logic pc_write;
  logic branch;
  logic ir_we;
  logic mem_we;
  logic reg_we;

  function automatic logic funct_supported(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100010, 6'b100100,
      6'b100101, 6'b100111, 6'b101010: funct_supported = 1'b1;
      default:                         funct_supported = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] funct_to_alu(input logic [5:0] f);
    case (f)
      6'b100000: funct_to_alu = ALU_ADD;
      6'b100010: funct_to_alu = ALU_SUB;
      6'b100100: funct_to_alu = ALU_AND;
      6'b100101: funct_to_alu = ALU_OR;
      6'b100111: funct_to_alu = ALU_NOR;
      6'b101010: funct_to_alu = ALU_SLT;
      default:   funct_to_alu = ALU_ADD;
    endcase
  endfunction

  // State register; reset aborts any instruction in flight back to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection; unused codes fall back to FETCH.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = funct_supported(funct) ? EXEC : FETCH;
          OP_BEQ:       state_d = BEQ;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  state_d = MEMWB;
      EXEC:   state_d = ALUWB;
      ADDIEX: state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // Per-state output decode; anything not set for a state stays 0.
  always_comb begin
    alu_control = 3'b000;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    pc_write    = 1'b0;
    branch      = 1'b0;
    i_or_d      = 1'b0;
    mem_we      = 1'b0;
    ir_we       = 1'b0;
    reg_we      = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    case (state_q)
      FETCH: begin
        ir_we       = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        pc_write    = 1'b1;
      end
      DECODE: begin
        // Branch target is precomputed into ALUOut while decoding.
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
      end
      MEMADR, ADDIEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
      end
      MEMRD: i_or_d = 1'b1;
      MEMWB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        i_or_d = 1'b1;
        mem_we = 1'b1;
      end
      EXEC: begin
        alu_src_a   = 1'b1;
        alu_control = funct_to_alu(funct);
      end
      ALUWB: begin
        reg_we  = 1'b1;
        reg_dst = 1'b1;
      end
      BEQ: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        branch      = 1'b1;
      end
      ADDIWB: reg_we = 1'b1;
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables are held off for as long as reset is asserted.
  assign pc_write_en = rst_n & (pc_write | (branch & zero));
  assign ir_write    = rst_n & ir_we;
  assign mem_write   = rst_n & mem_we;
  assign reg_write   = rst_n & reg_we;
  assign state       = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: random instruction stream checked against a
// behavioural model of per-instruction state sequences and per-state outputs.
module tb_mc_control_unit;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_write_en;
  logic       i_or_d;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  // Enables masked during reset: pc_write_en, mem_write, ir_write, reg_write.
  localparam logic [14:0] RST_MASK = 15'b000_0_00_00_1_0_1_1_1_0_0;

  logic [5:0] sup_f  [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
  logic [2:0] sup_ac [6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b011, 3'b111};

  int exp_seq[$];

  mc_control_unit dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .pc_write_en(pc_write_en), .i_or_d(i_or_d),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_sup(input logic [5:0] f);
    for (int i = 0; i < 6; i++) if (sup_f[i] == f) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    for (int i = 0; i < 6; i++) if (sup_f[i] == f) return sup_ac[i];
    return 3'b010;
  endfunction

  // State walk of one instruction, from FETCH up to (not including) the next FETCH.
  function automatic void build_seq(input logic [5:0] o, input logic [5:0] f);
    exp_seq = {};
    exp_seq.push_back(0);
    exp_seq.push_back(1);
    case (o)
      6'b100011: begin exp_seq.push_back(2); exp_seq.push_back(3); exp_seq.push_back(4); end
      6'b101011: begin exp_seq.push_back(2); exp_seq.push_back(5); end
      6'b000000: if (is_sup(f)) begin exp_seq.push_back(6); exp_seq.push_back(7); end
      6'b000100: exp_seq.push_back(8);
      6'b001000: begin exp_seq.push_back(9); exp_seq.push_back(10); end
      6'b000010: exp_seq.push_back(11);
      default: ;
    endcase
  endfunction

  // Expected outputs for a state, packed as
  // {alu_control, alu_src_a, alu_src_b, pc_src, pc_write_en, i_or_d,
  //  mem_write, ir_write, reg_write, reg_dst, mem_to_reg}.
  function automatic logic [14:0] exp_vec(input int st, input logic [5:0] f, input logic z);
    logic [2:0] ac = 3'b000;
    logic       sa = 1'b0;
    logic [1:0] sb = 2'b00;
    logic [1:0] ps = 2'b00;
    logic pw = 0, br = 0, iod = 0, mw = 0, irw = 0, rw = 0, rd = 0, m2r = 0;
    case (st)
      0:  begin ac = 3'b010; sb = 2'b01; irw = 1; pw = 1; end
      1:  begin ac = 3'b010; sb = 2'b11; end
      2:  begin ac = 3'b010; sa = 1; sb = 2'b10; end
      3:  iod = 1;
      4:  begin rw = 1; m2r = 1; end
      5:  begin iod = 1; mw = 1; end
      6:  begin sa = 1; ac = alu_of(f); end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; ac = 3'b110; ps = 2'b01; br = 1; end
      9:  begin ac = 3'b010; sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin ps = 2'b10; pw = 1; end
      default: ;
    endcase
    return {ac, sa, sb, ps, pw | (br & z), iod, mw, irw, rw, rd, m2r};
  endfunction

  function automatic logic [18:0] observed();
    return {state, alu_control, alu_src_a, alu_src_b, pc_src, pc_write_en, i_or_d,
            mem_write, ir_write, reg_write, reg_dst, mem_to_reg};
  endfunction

  task automatic check(input string tag, input logic [18:0] expv);
    logic [18:0] obs;
    obs = observed();
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (op=%b funct=%b zero=%b)", tag, obs, expv, op, funct, zero);
    end
  endtask

  task automatic check_excl();
    bit ok;
    ok = ($countones({ir_write, mem_write, reg_write}) <= 1) &&
         (!pc_write_en || !(mem_write || reg_write));
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL excl: observed ir=%b mw=%b rw=%b pcwe=%b expected at most one enable",
             ir_write, mem_write, reg_write, pc_write_en);
    end
  endtask

  // Runs one instruction. zsel<0 randomizes zero each cycle, else holds it.
  // action 1 at index at_idx: asynchronous reset for 3 cycles, then release.
  // action 2 at index at_idx: force an unused state code for one cycle.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zsel,
                           input int action, input int at_idx);
    build_seq(o, f);
    for (int idx = 0; idx < exp_seq.size(); idx++) begin
      if (idx == 0) begin
        op    = 6'($urandom);
        funct = 6'($urandom);
      end else begin
        op    = o;
        funct = f;
      end
      zero = (zsel < 0) ? 1'($urandom) : 1'(zsel);
      #1;
      check($sformatf("instr op=%b st%0d", o, exp_seq[idx]),
            {4'(exp_seq[idx]), exp_vec(exp_seq[idx], f, zero)});
      check_excl();
      if (action == 1 && idx == at_idx) begin
        #2 rst_n = 1'b0;
        #1 check("rst_async", {4'd0, exp_vec(0, f, zero) & ~RST_MASK});
        for (int c = 0; c < 3; c++) begin
          @(posedge clk); #1;
          check("rst_hold", {4'd0, exp_vec(0, f, zero) & ~RST_MASK});
        end
        rst_n = 1'b1;
        #1 check("rst_release", {4'd0, exp_vec(0, f, zero)});
        return;
      end
      if (action == 2 && idx == at_idx) begin
        #1 force dut.state_q = 4'd13;
        #1 check("illegal_state", {4'd13, 15'd0});
        #2 release dut.state_q;
        @(posedge clk); #1;
        check("illegal_recover", {4'd0, exp_vec(0, f, zero)});
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [5:0] ops [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    logic [5:0] ro, rf;
    int pick;

    rst_n = 1'b0; op = '0; funct = '0; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("reset_state", {4'd0, exp_vec(0, 6'd0, 1'b0) & ~RST_MASK});
    rst_n = 1'b1;

    // Directed instructions.
    run_instr(6'b100011, 6'd0, -1, 0, 0);
    for (int i = 0; i < 6; i++) run_instr(6'b000000, sup_f[i], -1, 0, 0);
    run_instr(6'b000000, 6'b000000, -1, 0, 0);
    run_instr(6'b000100, 6'd0, 1, 0, 0);
    run_instr(6'b000100, 6'd0, 0, 0, 0);
    run_instr(6'b001000, 6'd0, -1, 0, 0);
    run_instr(6'b101011, 6'd0, -1, 0, 0);
    run_instr(6'b000010, 6'd0, -1, 0, 0);
    run_instr(6'b111111, 6'd0, -1, 0, 0);

    // Reset mid-EXEC, then a normal instruction afterwards.
    run_instr(6'b000000, 6'b100000, -1, 1, 2);
    run_instr(6'b001000, 6'd0, -1, 0, 0);

    // Unused state code forced in place of MEMWB.
    run_instr(6'b100011, 6'd0, -1, 2, 4);

    // Random instruction stream.
    for (int n = 0; n < 200; n++) begin
      pick = $urandom_range(0, 7);
      rf = 6'($urandom);
      if (pick < 6) ro = ops[pick];
      else ro = 6'($urandom);
      if (pick == 2) rf = sup_f[$urandom_range(0, 5)];
      run_instr(ro, rf, -1, 0, 0);
    end

    #1 check("final_fetch", {4'd0, exp_vec(0, funct, zero)});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
